song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Drives the note-duration timer from the song ROM.
- Prefetches the next {note, duration} word from a synchronous song ROM and presents that duration on load_value, so the timer reloads it when the current note expires.
- Consumes the timer's expiry flag (note_done) to advance the current note, which it presents to the note player / frequency stage.
- Handles play/pause, restart, song select and end of song.

Parameters:
NOTE_W, 6, note code width (0 = rest/silence)
DUR_W, 9, duration width in 1/32 s ticks; equals the timer load width
SONG_W, 2, song select width
IDX_W, 5, note index width (32 entries per song)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
play  in  1  level; 1 = run, 0 = pause (hold all state)
restart  in  1  one-cycle pulse; restart the current song from index 0
song_sel  in  SONG_W  song select; a change acts as restart
note_done  in  1  timer expiry flag (high while timer value is 0)
rom_addr  out  SONG_W+IDX_W  registered ROM address {song_q, idx}
rom_data  in  NOTE_W+DUR_W  ROM word {note, duration}, valid 1 cycle after rom_addr
load_value  out  DUR_W  duration to the timer: prefetched duration when pre_valid, else 0
note  out  NOTE_W  current note; 0 = silence
new_note  out  1  one-cycle pulse in the cycle after note updates
song_done  out  1  one-cycle pulse when the end of song is consumed

Behaviour:
- Reset: state IDLE; idx=0; rom_addr=0; note=0; load_value=0; new_note=0; song_done=0; pre_valid=0; song_q=song_sel.
- States and transitions:
  - IDLE: play=1 -> FETCH.
  - FETCH: rom_addr <= {song_q, idx} already registered; go to LATCH.
  - LATCH: capture rom_data into pre_note/pre_dur; pre_valid=1; idx++; -> READY.
  - READY: consume when play=1 and note_done=1.
  - DONE: hold until restart, song_sel change or reset.
- End marker: rom_data == 0. A prefetched end marker gives load_value=0.
- Consume in READY:
  - note <= pre_note; new_note=1 next cycle; pre_valid <= 0.
  - If the consumed word was an end marker: note <= 0, song_done=1 next cycle, -> DONE.
  - Else if idx wrapped to 0 (all 32 entries fetched): load a synthetic end marker, pre_valid=1, -> READY without a ROM access.
  - Else -> FETCH.
- Prefetch latency: 3 rising edges from the edge that sampled play=1 in IDLE (or the edge that consumed) until READY and load_value valid.
- note_done while not READY (FETCH/LATCH): ignored. load_value=0 keeps the timer expired, so note_done stays high and is consumed once on reaching READY. Exactly one advance per READY entry.
- Pause: with play=0, all state is frozen (FETCH/LATCH still complete into READY). In READY no consume. IDLE does not start. DONE unchanged.
- restart=1 or song_sel != song_q, any state, highest priority after reset:
  - song_q <= song_sel; idx <= 0; pre_valid <= 0; note <= 0.
  - No new_note or song_done pulse.
  - Next state FETCH if play=1, else IDLE.
  - Overrides a simultaneous consume.
- Reset mid-operation returns to reset values at the next edge.
- Widths:
  - idx increments modulo 2^IDX_W.
  - load_value is pre_dur unmodified. Duration 0 inside a song is legal and yields an immediate next expiry.

Test Plan:
1. Song0 ROM = {(10,4),(20,2),0}; play=1; timer model loads load_value and counts every cycle -> note 10, then 20 five cycles later, then 0; load_value sequence 4, 2, 0; two new_note pulses, one song_done pulse; state DONE.
2. From IDLE, play rises -> rom_addr=0 after edge 1, LATCH at edge 2, load_value=4 after edge 3; note stays 0 until note_done consumed.
3. Hold note_done=1 continuously from reset -> first note consumed exactly once on reaching READY; no double advance during the next FETCH/LATCH.
4. In READY with note_done=1, drop play for 10 cycles -> note/rom_addr unchanged; play=1 -> advance in that cycle, new_note next cycle.
5. Mid-song, set song_sel 0->2 in the same cycle as a consume -> note=0, no new_note, rom_addr={2,0}, new song starts from index 0.
6. Song with 32 nonzero entries, no marker -> 32 new_note pulses, then synthetic end: note=0, song_done once, rom_addr never exceeds index 31.

Source files
------------

// File: rtl/song_sequencer.sv
// song_sequencer: steps through a song stored in a synchronous ROM.
// One {note, duration} word is prefetched ahead of the current note, so the
// note timer can reload the next duration when the current note expires.
// A ROM word of all zeros marks the end of a song. A song that fills all
// 32 entries ends with an end marker that is generated internally.
module song_sequencer #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 9,
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic                     restart,
  input  logic [SONG_W-1:0]        song_sel,
  input  logic                     note_done,
  output logic [SONG_W+IDX_W-1:0]  rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]  rom_data,
  output logic [DUR_W-1:0]         load_value,
  output logic [NOTE_W-1:0]        note,
  output logic                     new_note,
  output logic                     song_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_READY = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [NOTE_W-1:0] NOTE_ZERO = {NOTE_W{1'b0}};
  localparam logic [DUR_W-1:0]  DUR_ZERO  = {DUR_W{1'b0}};

  state_t                    state_r, state_s;
  logic [SONG_W-1:0]         song_q_r, song_q_s;
  logic [IDX_W-1:0]          idx_r, idx_s;
  logic [SONG_W+IDX_W-1:0]   rom_addr_r, rom_addr_s;
  logic [NOTE_W-1:0]         pre_note_r, pre_note_s;
  logic [DUR_W-1:0]          pre_dur_r, pre_dur_s;
  logic                      pre_valid_r, pre_valid_s;
  logic [NOTE_W-1:0]         note_r, note_s;
  logic [DUR_W-1:0]          load_value_r, load_value_s;
  logic                      new_note_r, new_note_s;
  logic                      song_done_r, song_done_s;
  logic                      restart_s;
  logic                      pre_end_s;

  // Next-state and next-output logic; a restart or song change overrides everything else.
  always_comb begin
    state_s     = state_r;
    song_q_s    = song_q_r;
    idx_s       = idx_r;
    rom_addr_s  = rom_addr_r;
    pre_note_s  = pre_note_r;
    pre_dur_s   = pre_dur_r;
    pre_valid_s = pre_valid_r;
    note_s      = note_r;
    new_note_s  = 1'b0;
    song_done_s = 1'b0;
    restart_s   = restart | (song_sel != song_q_r);
    pre_end_s   = (pre_note_r == NOTE_ZERO) && (pre_dur_r == DUR_ZERO);

    if (restart_s) begin
      song_q_s    = song_sel;
      idx_s       = IDX_ZERO;
      rom_addr_s  = {song_sel, IDX_ZERO};
      pre_valid_s = 1'b0;
      note_s      = NOTE_ZERO;
      if (play) begin
        state_s = ST_FETCH;
      end else begin
        state_s = ST_IDLE;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (play) begin
            rom_addr_s = {song_q_r, idx_r};
            state_s    = ST_FETCH;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          // The ROM is sampling rom_addr on this edge; its word arrives next cycle.
          state_s = ST_LATCH;
        end
        ST_LATCH: begin
          pre_note_s  = rom_data[NOTE_W+DUR_W-1:DUR_W];
          pre_dur_s   = rom_data[DUR_W-1:0];
          pre_valid_s = 1'b1;
          idx_s       = idx_r + IDX_ONE;
          state_s     = ST_READY;
        end
        ST_READY: begin
          if (play && note_done) begin
            pre_valid_s = 1'b0;
            if (pre_end_s) begin
              note_s      = NOTE_ZERO;
              song_done_s = 1'b1;
              state_s     = ST_DONE;
            end else begin
              note_s     = pre_note_r;
              new_note_s = 1'b1;
              if (idx_r == IDX_ZERO) begin
                // All entries already fetched: queue an end marker without a ROM access.
                pre_note_s  = NOTE_ZERO;
                pre_dur_s   = DUR_ZERO;
                pre_valid_s = 1'b1;
                state_s     = ST_READY;
              end else begin
                rom_addr_s = {song_q_r, idx_r};
                state_s    = ST_FETCH;
              end
            end
          end else begin
            state_s = ST_READY;
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end

    if (pre_valid_s) begin
      load_value_s = pre_dur_s;
    end else begin
      load_value_s = DUR_ZERO;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      song_q_r     <= song_sel;
      idx_r        <= IDX_ZERO;
      rom_addr_r   <= {SONG_W+IDX_W{1'b0}};
      pre_note_r   <= NOTE_ZERO;
      pre_dur_r    <= DUR_ZERO;
      pre_valid_r  <= 1'b0;
      note_r       <= NOTE_ZERO;
      load_value_r <= DUR_ZERO;
      new_note_r   <= 1'b0;
      song_done_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      song_q_r     <= song_q_s;
      idx_r        <= idx_s;
      rom_addr_r   <= rom_addr_s;
      pre_note_r   <= pre_note_s;
      pre_dur_r    <= pre_dur_s;
      pre_valid_r  <= pre_valid_s;
      note_r       <= note_s;
      load_value_r <= load_value_s;
      new_note_r   <= new_note_s;
      song_done_r  <= song_done_s;
    end
  end

  assign rom_addr   = rom_addr_r;
  assign load_value = load_value_r;
  assign note       = note_r;
  assign new_note   = new_note_r;
  assign song_done  = song_done_r;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: drives song_sequencer with a synchronous ROM and a
// countdown note timer, and compares every cycle against a reference model
// that tracks the song position, the outstanding fetch delay and the
// prefetched word.
module tb_song_sequencer;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 9;
  localparam int SONG_W = 2;
  localparam int IDX_W  = 5;
  localparam int WORD_W = NOTE_W + DUR_W;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    play;
  logic                    restart;
  logic [SONG_W-1:0]       song_sel;
  logic                    note_done;
  logic [SONG_W+IDX_W-1:0] rom_addr;
  logic [WORD_W-1:0]       rom_data = '0;
  logic [DUR_W-1:0]        load_value;
  logic [NOTE_W-1:0]       note;
  logic                    new_note;
  logic                    song_done;

  logic [WORD_W-1:0] rom_mem [0:127];

  song_sequencer #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .SONG_W(SONG_W), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .restart    (restart),
    .song_sel   (song_sel),
    .note_done  (note_done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .load_value (load_value),
    .note       (note),
    .new_note   (new_note),
    .song_done  (song_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Synchronous song ROM: word appears one cycle after the address.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the song position.
  int m_song, m_idx, m_addr, m_note, m_word, m_wait;
  bit m_have, m_started, m_done, m_new_note, m_song_done;
  int timer;
  int nd_mode;       // 0 timer, 1 always high, 2 always low, 3 random
  int pulses_new, pulses_done;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int exp_load();
    return m_have ? (m_word % 512) : 0;
  endfunction

  function automatic bit model_ready();
    return m_started && !m_done && (m_wait == 0);
  endfunction

  task automatic model_step(input bit r, input bit p, input bit rs, input int ss, input bit nd);
    m_new_note  = 1'b0;
    m_song_done = 1'b0;
    if (r) begin
      m_song = ss; m_idx = 0; m_addr = 0; m_note = 0; m_word = 0;
      m_have = 1'b0; m_started = 1'b0; m_done = 1'b0; m_wait = 0;
    end else if (rs || ss != m_song) begin
      m_song = ss; m_idx = 0; m_have = 1'b0; m_note = 0; m_done = 1'b0;
      m_addr = ss * 32;
      m_started = p;
      m_wait = p ? 2 : 0;
    end else if (m_done) begin
      m_done = 1'b1;
    end else if (!m_started) begin
      if (p) begin
        m_started = 1'b1; m_wait = 2; m_addr = m_song * 32 + m_idx;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_word = int'(rom_mem[m_song * 32 + m_idx]);
        m_idx  = (m_idx + 1) % 32;
        m_have = 1'b1;
      end
    end else if (p && nd) begin
      m_have = 1'b0;
      if (m_word == 0) begin
        m_note = 0; m_song_done = 1'b1; m_done = 1'b1;
      end else begin
        m_note = m_word / 512;
        m_new_note = 1'b1;
        if (m_idx == 0) begin
          m_word = 0; m_have = 1'b1;
        end else begin
          m_wait = 2; m_addr = m_song * 32 + m_idx;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_val("note", note, m_note);
    check_val("load_value", load_value, exp_load());
    check_val("new_note", new_note, m_new_note);
    check_val("song_done", song_done, m_song_done);
    check_val("rom_addr", rom_addr, m_addr);
  endtask

  // One clock: apply inputs (set by caller), advance timer and model, check after the edge.
  task automatic do_cycle();
    int ld;
    ld = exp_load();
    case (nd_mode)
      0:       note_done = (timer == 0);
      1:       note_done = 1'b1;
      2:       note_done = 1'b0;
      default: note_done = 1'($urandom_range(0, 1));
    endcase
    if (reset) timer = 0;
    else if (timer == 0) timer = ld;
    else timer--;
    model_step(reset, play, restart, int'(song_sel), note_done);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    if (new_note) pulses_new++;
    if (song_done) pulses_done++;
  endtask

  task automatic do_reset(input int ss);
    reset = 1'b1; play = 1'b0; restart = 1'b0; song_sel = SONG_W'(ss);
    do_cycle();
    do_cycle();
    reset = 1'b0;
    pulses_new = 0; pulses_done = 0;
  endtask

  initial begin
    int n, d, mark;
    bit found;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 32; i++) begin
        n = $urandom_range(0, 63);
        d = $urandom_range(0, 6);
        if (n == 0 && d == 0) d = 1;
        rom_mem[s * 32 + i] = WORD_W'(n * 512 + d);
      end
    end
    rom_mem[0] = WORD_W'(10 * 512 + 4);
    rom_mem[1] = WORD_W'(20 * 512 + 2);
    rom_mem[2] = '0;
    mark = $urandom_range(3, 10);
    rom_mem[32 + mark] = '0;
    mark = $urandom_range(4, 12);
    rom_mem[64 + mark] = '0;

    reset = 1'b1; play = 1'b0; restart = 1'b0; song_sel = '0; note_done = 1'b0;
    nd_mode = 2; timer = 0;

    // Play start latency, then the three-word song with the timer in the loop.
    do_reset(0);
    do_cycle();
    play = 1'b1;
    do_cycle();
    check_val("t2_addr_after_edge1", rom_addr, 0);
    do_cycle();
    do_cycle();
    check_val("t2_load_after_edge3", load_value, 4);
    check_val("t2_note_still_0", note, 0);
    nd_mode = 0;
    timer = 0;
    repeat (30) do_cycle();
    check_val("t1_new_note_pulses", pulses_new, 2);
    check_val("t1_song_done_pulses", pulses_done, 1);
    check_val("t1_final_note", note, 0);

    // note_done held high from reset: each word consumed exactly once.
    nd_mode = 1;
    do_reset(0);
    play = 1'b1;
    repeat (25) do_cycle();
    check_val("t3_new_note_pulses", pulses_new, 2);
    check_val("t3_song_done_pulses", pulses_done, 1);

    // Pause while READY with note_done high.
    nd_mode = 2;
    do_reset(1);
    play = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      do_cycle();
      if (model_ready()) found = 1'b1;
    end
    check_val("t4_reached_ready", found, 1);
    nd_mode = 1;
    play = 1'b0;
    repeat (10) do_cycle();
    check_val("t4_paused_note", note, 0);
    check_val("t4_paused_addr", rom_addr, 32);
    play = 1'b1;
    do_cycle();
    check_val("t4_resume_new_note", new_note, 1);
    check_val("t4_resume_note", note, rom_mem[32] / 512);

    // Song change in the same cycle as a consume.
    nd_mode = 0;
    do_reset(0);
    timer = 0;
    play = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (pulses_new >= 1 && model_ready() && timer == 0) begin
        song_sel = 2'd2;
        do_cycle();
        found = 1'b1;
      end else begin
        do_cycle();
      end
    end
    check_val("t5_consume_found", found, 1);
    check_val("t5_note_cleared", note, 0);
    check_val("t5_no_new_note", new_note, 0);
    check_val("t5_addr_song2", rom_addr, 64);
    repeat (40) do_cycle();

    // Full 32-entry song ends with a synthetic end marker.
    nd_mode = 1;
    song_sel = 2'd3;
    pulses_new = 0; pulses_done = 0;
    repeat (140) do_cycle();
    check_val("t6_new_note_pulses", pulses_new, 32);
    check_val("t6_song_done_pulses", pulses_done, 1);
    check_val("t6_final_note", note, 0);

    // Random play, restart, song select, reset and note_done patterns.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) nd_mode = $urandom_range(0, 3);
      play    = ($urandom_range(0, 9) != 0);
      restart = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 149) == 0) song_sel = SONG_W'($urandom_range(0, 3));
      reset   = ($urandom_range(0, 499) == 0);
      do_cycle();
    end
    reset = 1'b0; restart = 1'b0;
    do_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
